sram_port_arbiter: RTL and testbench
====================================

SRAM_PORT_ARBITER -- requirements
Module: sram_port_arbiter

Interface
REQ-001 Parameter MEM_AWIDTH, default 19, SRAM address width.
REQ-002 Parameter TIMEOUT, default 16 (8-bit), maximum SERVE cycles without mem_ack; 0 disables the timeout.
REQ-003 HCLK  in  1  single clock; all logic on rising edge.
REQ-004 HRESET  in  1  reset, synchronous and active-high.
REQ-005 p0_req, p1_req  in  1  level request, held until ack or err.
REQ-006 p0_lock, p1_lock  in  1  keep grant after ack (burst).
REQ-007 p0_write, p1_write  in  1  write/read select.
REQ-008 p0_size, p1_size  in  3  HSIZE encoding.
REQ-009 p0_addr, p1_addr  in  MEM_AWIDTH  byte address.
REQ-010 p0_wdata, p1_wdata  in  32  write data.
REQ-011 p0_ack, p1_ack  out  1  one-cycle completion pulse.
REQ-012 p0_err, p1_err  out  1  one-cycle timeout pulse.
REQ-013 p0_rdata, p1_rdata  out  32  read data, valid when ack is high.
REQ-014 p0_busy, p1_busy  out  1  other port owns the SRAM.
REQ-015 mem_req  out  1  SRAM request, level, held until mem_ack.
REQ-016 mem_write, mem_size[2:0], mem_addr[MEM_AWIDTH-1:0], mem_wdata[31:0]  out  SRAM command from owner.
REQ-017 mem_ack  in  1  one-cycle SRAM completion; mem_rdata  in  32  read data, valid with mem_ack.

Function
REQ-018 The FSM SHALL have states IDLE, SERVE and HOLD, plus a registered owner bit (0/1).
REQ-019 IDLE: if any pX_req is high, the arbiter SHALL register the winner as owner and move to SERVE next cycle; mem_req stays 0 in IDLE.
REQ-020 SERVE: mem_req SHALL be 1, and mem_write/size/addr/wdata SHALL be muxed combinationally from the owner's inputs.
REQ-021 In SERVE with mem_ack=1, the arbiter SHALL pulse owner pX_ack the same cycle; pX_rdata SHALL equal mem_rdata for both ports at all times.
REQ-022 On ack with owner lock=0: next state IDLE (one turnaround cycle minimum between grants).
REQ-023 On ack with owner lock=1: next state HOLD, owner unchanged.
REQ-024 HOLD: mem_req=0; owner req=1 -> SERVE; owner lock=0 and req=0 -> IDLE; the other port SHALL NOT be granted.
REQ-025 A wait counter SHALL clear on entry to SERVE and increment each SERVE cycle without mem_ack.
REQ-026 If TIMEOUT!=0 and the counter reaches TIMEOUT with mem_ack=0, the arbiter SHALL pulse owner pX_err, drop mem_req, and go to IDLE; no ack is issued.
REQ-027 mem_ack arriving on the timeout cycle SHALL take priority: ack is issued, err is not.
REQ-028 mem_ack outside SERVE SHALL be ignored.
REQ-029 pX_busy SHALL be 1 iff state!=IDLE and owner!=X.
REQ-030 A requester dropping req mid-SERVE is a protocol violation; the arbiter SHALL keep mem_req until ack or timeout regardless.

Reset
REQ-031 HRESET=1 at any edge, including mid-SERVE, SHALL force state IDLE, owner 0, last_owner 1, and counter 0.
REQ-032 During and after reset, all outputs (mem_req, ack, err, busy) SHALL be 0; an outstanding transaction is dropped without ack or err.

Configuration
REQ-033 Macro SRAM_ARB_ROUND_ROBIN_EN defined: on simultaneous requests in IDLE, the arbiter SHALL grant the port != last_owner; last_owner updates on every grant.
REQ-034 Macro SRAM_ARB_ROUND_ROBIN_EN undefined: fixed priority, with p0 always winning ties; last_owner logic is absent.

Verification
REQ-035 p0_req with addr 0x100 write, mem_ack 2 cycles after mem_req -> mem_addr=0x100, mem_write=1, p0_ack pulses with mem_ack, p1_busy=1 throughout.
REQ-036 p0_req and p1_req both held for 4 transactions -> RR: grants 0,1,0,1; fixed: grants 0,0,0,0 with p1 starved.
REQ-037 p1_lock=1, 4-beat burst while p0_req held -> all 4 p1 acks before any p0 grant; p0_busy=1 during HOLD.
REQ-038 TIMEOUT=4, mem_ack never asserted -> p0_err pulses on 4th SERVE cycle, mem_req=0 next cycle, no p0_ack.
REQ-039 TIMEOUT=4, mem_ack on exactly the timeout cycle -> p0_ack=1, p0_err=0.
REQ-040 HRESET asserted mid-SERVE -> next cycle mem_req=0, all ack/err/busy=0, state IDLE; mem_ack after reset is ignored.

Source files
------------

// File: rtl/sram_port_arbiter.sv
// Two-port SRAM arbiter: grants one of two requesters access to a single
// SRAM command port, with optional burst hold (lock) and a wait timeout.
// Optional feature: define SRAM_ARB_ROUND_ROBIN_EN for round-robin tie
// breaking; otherwise p0 wins simultaneous requests.
//
// state | meaning
// IDLE  | no owner active; pick a winner from pending requests
// SERVE | owner's command is presented to the SRAM, waiting for mem_ack
// HOLD  | owner keeps the grant between burst beats (lock=1)
module sram_port_arbiter #(
    parameter int unsigned MEM_AWIDTH = 19,
    parameter logic [7:0]  TIMEOUT    = 8'd16
) (
    input  logic                  HCLK,
    input  logic                  HRESET,
    input  logic                  p0_req,
    input  logic                  p1_req,
    input  logic                  p0_lock,
    input  logic                  p1_lock,
    input  logic                  p0_write,
    input  logic                  p1_write,
    input  logic [2:0]            p0_size,
    input  logic [2:0]            p1_size,
    input  logic [MEM_AWIDTH-1:0] p0_addr,
    input  logic [MEM_AWIDTH-1:0] p1_addr,
    input  logic [31:0]           p0_wdata,
    input  logic [31:0]           p1_wdata,
    output logic                  p0_ack,
    output logic                  p1_ack,
    output logic                  p0_err,
    output logic                  p1_err,
    output logic [31:0]           p0_rdata,
    output logic [31:0]           p1_rdata,
    output logic                  p0_busy,
    output logic                  p1_busy,
    output logic                  mem_req,
    output logic                  mem_write,
    output logic [2:0]            mem_size,
    output logic [MEM_AWIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    input  logic                  mem_ack,
    input  logic [31:0]           mem_rdata
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SERVE = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t     state, state_nxt;
    logic       owner, owner_nxt;
    logic [7:0] wait_cnt, wait_cnt_nxt;
    logic       winner;
    logic       own_req, own_lock;
    logic       timeout_hit;
    logic       ack_own, err_own;

`ifdef SRAM_ARB_ROUND_ROBIN_EN
    logic       last_owner, last_owner_nxt;
`endif

    assign own_req   = owner ? p1_req  : p0_req;
    assign own_lock  = owner ? p1_lock : p0_lock;

    // Command path follows the registered owner; only meaningful in SERVE.
    assign mem_write = owner ? p1_write : p0_write;
    assign mem_size  = owner ? p1_size  : p0_size;
    assign mem_addr  = owner ? p1_addr  : p0_addr;
    assign mem_wdata = owner ? p1_wdata : p0_wdata;

    assign p0_rdata  = mem_rdata;
    assign p1_rdata  = mem_rdata;

    // wait_cnt holds the number of earlier SERVE cycles without ack, so the
    // TIMEOUT-th waiting cycle is the one where it equals TIMEOUT-1.
    assign timeout_hit = (TIMEOUT != 8'd0) && (wait_cnt == (TIMEOUT - 8'd1));

    // Winner selection among pending requests in IDLE.
    always_comb begin
`ifdef SRAM_ARB_ROUND_ROBIN_EN
        winner = (p0_req && p1_req) ? ~last_owner : ~p0_req;
`else
        winner = ~p0_req;
`endif
    end

    // Next-state logic and all control outputs.
    always_comb begin
        state_nxt    = state;
        owner_nxt    = owner;
        wait_cnt_nxt = wait_cnt;
        mem_req      = 1'b0;
        ack_own      = 1'b0;
        err_own      = 1'b0;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
        last_owner_nxt = last_owner;
`endif
        case (state)
            IDLE: begin
                if (p0_req || p1_req) begin
                    state_nxt    = SERVE;
                    owner_nxt    = winner;
                    wait_cnt_nxt = 8'd0;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
                    last_owner_nxt = winner;
`endif
                end
            end
            SERVE: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    ack_own   = 1'b1;
                    state_nxt = own_lock ? HOLD : IDLE;
                end else if (timeout_hit) begin
                    err_own   = 1'b1;
                    state_nxt = IDLE;
                end else if (wait_cnt != 8'hFF) begin
                    wait_cnt_nxt = wait_cnt + 8'd1;
                end
            end
            HOLD: begin
                if (own_req) begin
                    state_nxt    = SERVE;
                    wait_cnt_nxt = 8'd0;
                end else if (!own_lock) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        p0_ack  = ack_own & ~owner;
        p1_ack  = ack_own &  owner;
        p0_err  = err_own & ~owner;
        p1_err  = err_own &  owner;
        p0_busy = (state != IDLE) &&  owner;
        p1_busy = (state != IDLE) && !owner;

        // Reset silences the outputs immediately, even before the edge that
        // returns the FSM to IDLE.
        if (HRESET) begin
            mem_req = 1'b0;
            p0_ack  = 1'b0;
            p1_ack  = 1'b0;
            p0_err  = 1'b0;
            p1_err  = 1'b0;
            p0_busy = 1'b0;
            p1_busy = 1'b0;
        end
    end

    // State, owner and wait counter registers.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state    <= IDLE;
            owner    <= 1'b0;
            wait_cnt <= 8'd0;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
            last_owner <= 1'b1;
`endif
        end else begin
            state    <= state_nxt;
            owner    <= owner_nxt;
            wait_cnt <= wait_cnt_nxt;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
            last_owner <= last_owner_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed self-checking bench for sram_port_arbiter (TIMEOUT=4).
module tb_sram_port_arbiter;

    localparam int unsigned AW = 19;

    logic          HCLK, HRESET;
    logic          p0_req, p1_req, p0_lock, p1_lock, p0_write, p1_write;
    logic [2:0]    p0_size, p1_size;
    logic [AW-1:0] p0_addr, p1_addr;
    logic [31:0]   p0_wdata, p1_wdata;
    logic          p0_ack, p1_ack, p0_err, p1_err, p0_busy, p1_busy;
    logic [31:0]   p0_rdata, p1_rdata;
    logic          mem_req, mem_write, mem_ack;
    logic [2:0]    mem_size;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata, mem_rdata;

    // {mem_req, p0_ack, p1_ack, p0_err, p1_err, p0_busy, p1_busy}
    logic [6:0]    st;
    assign st = {mem_req, p0_ack, p1_ack, p0_err, p1_err, p0_busy, p1_busy};

    int checks = 0;
    int errors = 0;

    sram_port_arbiter #(.MEM_AWIDTH(AW), .TIMEOUT(8'd4)) dut (
        .HCLK(HCLK), .HRESET(HRESET),
        .p0_req(p0_req), .p1_req(p1_req),
        .p0_lock(p0_lock), .p1_lock(p1_lock),
        .p0_write(p0_write), .p1_write(p1_write),
        .p0_size(p0_size), .p1_size(p1_size),
        .p0_addr(p0_addr), .p1_addr(p1_addr),
        .p0_wdata(p0_wdata), .p1_wdata(p1_wdata),
        .p0_ack(p0_ack), .p1_ack(p1_ack),
        .p0_err(p0_err), .p1_err(p1_err),
        .p0_rdata(p0_rdata), .p1_rdata(p1_rdata),
        .p0_busy(p0_busy), .p1_busy(p1_busy),
        .mem_req(mem_req), .mem_write(mem_write), .mem_size(mem_size),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    initial begin
        HCLK = 1'b0;
        forever #5 HCLK = ~HCLK;
    end

    initial begin
        #100000;
        $display("FAIL watchdog simulation did not finish, errors so far %0d", errors);
        $fatal(1);
    end

    task automatic nxt();
        @(negedge HCLK);
    endtask

    task automatic apply_reset();
        nxt();
        HRESET = 1'b1;
        nxt();
        nxt();
        HRESET = 1'b0;
    endtask

    task automatic test_reset();
        HRESET = 1'b1;
        p0_req = 1'b1;
        nxt();
        nxt();
        #1;
        checks++;
        if (st !== 7'b0000000) begin
            errors++; $display("FAIL reset_outputs st=%b exp=%b", st, 7'b0000000);
        end
        HRESET = 1'b0;
        p0_req = 1'b0;
        nxt();
        #1;
        checks++;
        if (st !== 7'b0000000) begin
            errors++; $display("FAIL reset_release st=%b exp=%b", st, 7'b0000000);
        end
    endtask

    task automatic test_single_write();
        nxt();
        p0_req = 1'b1; p0_write = 1'b1; p0_addr = 19'h100;
        p0_size = 3'd2; p0_wdata = 32'hDEADBEEF;
        #1;
        checks++;
        if (st !== 7'b0000000) begin
            errors++; $display("FAIL single_idle st=%b exp=%b", st, 7'b0000000);
        end
        nxt(); #1;
        checks++;
        if (st !== 7'b1000001) begin
            errors++; $display("FAIL single_serve1 st=%b exp=%b", st, 7'b1000001);
        end
        checks++;
        if ({mem_write, mem_size, mem_addr, mem_wdata} !== {1'b1, 3'd2, 19'h100, 32'hDEADBEEF}) begin
            errors++;
            $display("FAIL single_cmd got w=%b sz=%0d a=%h d=%h exp w=1 sz=2 a=100 d=deadbeef",
                     mem_write, mem_size, mem_addr, mem_wdata);
        end
        nxt(); #1;
        checks++;
        if (st !== 7'b1000001) begin
            errors++; $display("FAIL single_serve2 st=%b exp=%b", st, 7'b1000001);
        end
        nxt();
        mem_ack = 1'b1; mem_rdata = 32'h12345678;
        #1;
        checks++;
        if (st !== 7'b1100001) begin
            errors++; $display("FAIL single_ack st=%b exp=%b", st, 7'b1100001);
        end
        checks++;
        if ({p0_rdata, p1_rdata} !== {32'h12345678, 32'h12345678}) begin
            errors++; $display("FAIL single_rdata got %h %h exp 12345678", p0_rdata, p1_rdata);
        end
        nxt();
        mem_ack = 1'b0; p0_req = 1'b0; p0_write = 1'b0;
        #1;
        checks++;
        if (st !== 7'b0000000) begin
            errors++; $display("FAIL single_done st=%b exp=%b", st, 7'b0000000);
        end
    endtask

    task automatic test_arbitration();
        logic       exp_own;
        logic [6:0] exp_st;
        apply_reset();
        p0_req = 1'b1; p1_req = 1'b1;
        p0_addr = 19'h10; p1_addr = 19'h20;
        #1;
        checks++;
        if (st !== 7'b0000000) begin
            errors++; $display("FAIL arb_idle st=%b exp=%b", st, 7'b0000000);
        end
        for (int i = 0; i < 4; i++) begin
`ifdef SRAM_ARB_ROUND_ROBIN_EN
            exp_own = i[0];
`else
            exp_own = 1'b0;
`endif
            exp_st = exp_own ? 7'b1010010 : 7'b1100001;
            nxt();
            mem_ack = 1'b1;
            #1;
            checks++;
            if (mem_addr !== (exp_own ? 19'h20 : 19'h10)) begin
                errors++; $display("FAIL arb_grant%0d addr=%h exp_owner=%0d", i, mem_addr, exp_own);
            end
            checks++;
            if (st !== exp_st) begin
                errors++; $display("FAIL arb_ack%0d st=%b exp=%b", i, st, exp_st);
            end
            nxt();
            mem_ack = 1'b0;
            #1;
            checks++;
            if (st !== 7'b0000000) begin
                errors++; $display("FAIL arb_turnaround%0d st=%b exp=%b", i, st, 7'b0000000);
            end
        end
        p0_req = 1'b0; p1_req = 1'b0;
    endtask

    task automatic test_lock_burst();
        apply_reset();
        p1_req = 1'b1; p1_lock = 1'b1;
        p0_addr = 19'h10; p1_addr = 19'h20;
        #1;
        checks++;
        if (st !== 7'b0000000) begin
            errors++; $display("FAIL burst_idle st=%b exp=%b", st, 7'b0000000);
        end
        nxt();
        p0_req = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            mem_ack = 1'b1;
            p1_lock = (k < 4);
            #1;
            checks++;
            if (st !== 7'b1010010 || mem_addr !== 19'h20) begin
                errors++; $display("FAIL burst_beat%0d st=%b addr=%h exp st=1010010 addr=20", k, st, mem_addr);
            end
            nxt();
            mem_ack = 1'b0;
            if (k < 4) begin
                #1;
                checks++;
                if (st !== 7'b0000010) begin
                    errors++; $display("FAIL burst_hold%0d st=%b exp=%b", k, st, 7'b0000010);
                end
                nxt();
            end
        end
        p1_req = 1'b0;
        #1;
        checks++;
        if (st !== 7'b0000000) begin
            errors++; $display("FAIL burst_release st=%b exp=%b", st, 7'b0000000);
        end
        nxt();
        mem_ack = 1'b1;
        #1;
        checks++;
        if (st !== 7'b1100001 || mem_addr !== 19'h10) begin
            errors++; $display("FAIL burst_p0_grant st=%b addr=%h exp st=1100001 addr=10", st, mem_addr);
        end
        nxt();
        mem_ack = 1'b0; p0_req = 1'b0;
        #1;
        checks++;
        if (st !== 7'b0000000) begin
            errors++; $display("FAIL burst_done st=%b exp=%b", st, 7'b0000000);
        end
    endtask

    task automatic test_timeout();
        nxt();
        p0_req = 1'b1; p0_addr = 19'h44;
        #1;
        for (int c = 1; c <= 3; c++) begin
            nxt(); #1;
            checks++;
            if (st !== 7'b1000001) begin
                errors++; $display("FAIL tmo_wait%0d st=%b exp=%b", c, st, 7'b1000001);
            end
        end
        nxt(); #1;
        checks++;
        if (st !== 7'b1001001) begin
            errors++; $display("FAIL tmo_err st=%b exp=%b", st, 7'b1001001);
        end
        nxt();
        p0_req = 1'b0;
        #1;
        checks++;
        if (st !== 7'b0000000) begin
            errors++; $display("FAIL tmo_after st=%b exp=%b", st, 7'b0000000);
        end
    endtask

    task automatic test_timeout_ack();
        nxt();
        p0_req = 1'b1;
        #1;
        for (int c = 1; c <= 3; c++) begin
            nxt(); #1;
            checks++;
            if (st !== 7'b1000001) begin
                errors++; $display("FAIL tmoack_wait%0d st=%b exp=%b", c, st, 7'b1000001);
            end
        end
        nxt();
        mem_ack = 1'b1;
        #1;
        checks++;
        if (st !== 7'b1100001) begin
            errors++; $display("FAIL tmoack_prio st=%b exp=%b", st, 7'b1100001);
        end
        nxt();
        mem_ack = 1'b0; p0_req = 1'b0;
        #1;
        checks++;
        if (st !== 7'b0000000) begin
            errors++; $display("FAIL tmoack_after st=%b exp=%b", st, 7'b0000000);
        end
    endtask

    task automatic test_reset_mid_serve();
        nxt();
        p0_req = 1'b1;
        #1;
        nxt(); #1;
        checks++;
        if (st !== 7'b1000001) begin
            errors++; $display("FAIL rstmid_serve st=%b exp=%b", st, 7'b1000001);
        end
        HRESET = 1'b1;
        #1;
        checks++;
        if (st !== 7'b0000000) begin
            errors++; $display("FAIL rstmid_during st=%b exp=%b", st, 7'b0000000);
        end
        nxt();
        mem_ack = 1'b1;
        #1;
        checks++;
        if (st !== 7'b0000000) begin
            errors++; $display("FAIL rstmid_next st=%b exp=%b", st, 7'b0000000);
        end
        nxt();
        HRESET = 1'b0; p0_req = 1'b0;
        #1;
        checks++;
        if (st !== 7'b0000000) begin
            errors++; $display("FAIL rstmid_stray_ack st=%b exp=%b", st, 7'b0000000);
        end
        nxt();
        mem_ack = 1'b0;
        #1;
        checks++;
        if (st !== 7'b0000000) begin
            errors++; $display("FAIL rstmid_idle st=%b exp=%b", st, 7'b0000000);
        end
    endtask

    initial begin
        HRESET = 1'b1;
        p0_req = 1'b0; p1_req = 1'b0; p0_lock = 1'b0; p1_lock = 1'b0;
        p0_write = 1'b0; p1_write = 1'b0; p0_size = 3'd0; p1_size = 3'd0;
        p0_addr = '0; p1_addr = '0; p0_wdata = '0; p1_wdata = 32'hCAFEF00D;
        mem_ack = 1'b0; mem_rdata = '0;
        nxt();
        test_reset();
        test_single_write();
        test_arbitration();
        test_lock_burst();
        test_timeout();
        test_timeout_ack();
        test_reset_mid_serve();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
